priority_encoder83: RTL and testbench
=====================================

# priority_encoder83

Registered 8-to-3 priority encoder with a valid/ack handshake. It is the encoding end of the 3-to-8 decoder path. Request lines are latched into a pending register, and the highest-numbered pending line is presented as a 3-bit code. The code is held until the consumer (typically the decoder's select inputs) acknowledges it. After that the granted bit is cleared and the next one is encoded.

## Interface
Parameters:
- none; the width is fixed at 8 requests and a 3-bit code.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset; synchronous, active-low.
- en  input  1  grant enable; active-high. Gates new grants only.
- req  input  8  request lines, sampled every clk edge; any high bit sets the matching pending bit.
- ack  input  1  consumer acknowledge; meaningful only while valid=1.
- code  output  3  index of the granted request; 7 is the highest priority.
- valid  output  1  code holds a grant not yet acknowledged.
- gs  output  1  group select; 1 when any pending bit is set, including the granted one.
- pending  output  8  current pending register, for observation.
- overrun  output  1  sticky error flag; present only with PENC_OVERRUN_EN.

## Operation
- All state is registered on clk.
- Reset (rst_n=0 at an edge) gives:
  - pending=8'h00, code=3'd0, valid=0, gs=0, overrun=0;
  - state=IDLE.
- Reset takes priority over every other event, including mid-handshake.
- Pending update at each edge: pending_next = (pending & ~clear_mask) | req.
  - clear_mask is the one-hot of code when valid & ack; otherwise 0.
  - If set and clear hit the same bit, set wins and the bit stays pending.
- State machine:
  - IDLE: if en=1 and pending!=0 at an edge, then code is loaded with the highest set index of pending (the pre-update value), valid goes to 1, and the state moves to HOLD. Otherwise stay in IDLE with valid=0 and code holding its last value.
  - HOLD: code and valid are held stable regardless of en or req. When ack=1 at an edge, clear pending[code], set valid to 0 and return to IDLE.
- en=0 while in HOLD does not withdraw the grant; the handshake completes normally.
- ack while valid=0 is ignored.
- gs = |pending, taken from the registered pending value.
- Priority is strict (7 > 6 > … > 0) with no fairness mechanism. A continuously re-asserted high-index request can starve lower ones.

## Timing
- req sampled high at edge N:
  - pending is set after edge N;
  - with the machine in IDLE and en=1, valid=1 and code are visible after edge N+1 (2-cycle latency).
- ack sampled at edge M: valid=0 after M and the state is IDLE. The earliest next grant is valid after M+1, so there is a mandatory one-cycle bubble with valid=0 between grants.
- code is guaranteed stable for every cycle in which valid=1.
- Maximum throughput is one grant per 2 cycles, reached when ack is tied high.
- Outputs are all registered; there is no combinational path from inputs to outputs.

## Configuration
- PENC_OVERRUN_EN defined:
  - overrun sets to 1 at any edge where req[i]=1 while pending[i]=1 and bit i is not being cleared at that same edge;
  - the flag is sticky and cleared only by reset.
- PENC_OVERRUN_EN undefined: the overrun port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset mid-HOLD:
  - Stimulus: pending=8'hA0, valid=1 with code=7, then rst_n=0 for one edge.
  - Required: pending=0, valid=0, code=0 and gs=0 on the next cycle; the pulse on ack is ignored.
- Priority ordering:
  - Stimulus: a single-cycle req=8'b0010_0110, en=1, ack tied high.
  - Required: the grant sequence is code 5, 2, 1. Each grant has valid high for 1 cycle, separated by 1-cycle bubbles, and pending=0 and gs=0 at the end.
- Hold under pressure:
  - Stimulus: code=3 is granted with ack=0; then req=8'h80 arrives and en=0 for 4 cycles.
  - Required: code stays 3 and valid stays 1 throughout. After ack, the next grant is code 7 only once en=1.
- Set-wins collision:
  - Stimulus: code=4 is granted; ack=1 and req[4]=1 at the same edge.
  - Required: pending[4] remains 1, and the next grant (en=1) is code 4 again.
- Enable gating:
  - Stimulus: en=0 and req=8'h01.
  - Required: valid stays 0 while gs=1 and pending=8'h01. Raising en produces valid=1 with code=0 one edge later.
- Overrun (build with PENC_OVERRUN_EN defined):
  - Stimulus: with pending[6]=1 and not being cleared, req[6]=1.
  - Required: overrun=1 and it stays 1 until reset. Rebuild with the macro undefined and confirm there is no overrun port and the grant behaviour is identical.

Source files
------------

// File: rtl/priority_encoder83.sv
// rtl/priority_encoder83.sv - registered 8-to-3 priority encoder with valid/ack handshake
// Optional sticky overrun flag and port enabled by defining PENC_OVERRUN_EN.
module priority_encoder83 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       ack,
    output logic [2:0] code,
    output logic       valid,
    output logic       gs,
    output logic [7:0] pending
`ifdef PENC_OVERRUN_EN
    ,
    output logic       overrun
`endif
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] code_q, code_d;
    logic [7:0] pending_q, pending_d;
    logic [7:0] clear_mask;
    logic [2:0] top_index;

`ifdef PENC_OVERRUN_EN
    logic       overrun_q, overrun_d;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            code_q    <= 3'd0;
            pending_q <= 8'h00;
`ifdef PENC_OVERRUN_EN
            overrun_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            pending_q <= pending_d;
`ifdef PENC_OVERRUN_EN
            overrun_q <= overrun_d;
`endif
        end
    end

    // Ascending scan so the highest set bit wins.
    always_comb begin
        top_index = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (pending_q[i]) begin
                top_index = i[2:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        clear_mask = 8'h00;
        case (state_q)
            S_IDLE: begin
                if (en && (pending_q != 8'h00)) begin
                    code_d  = top_index;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (ack) begin
                    clear_mask = 8'h01 << code_q;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A request arriving on the bit being cleared keeps it pending.
        pending_d = (pending_q & ~clear_mask) | req;
`ifdef PENC_OVERRUN_EN
        overrun_d = overrun_q | (|(req & pending_q & ~clear_mask));
`endif
    end

    always_comb begin
        code    = code_q;
        valid   = (state_q == S_HOLD);
        gs      = |pending_q;
        pending = pending_q;
`ifdef PENC_OVERRUN_EN
        overrun = overrun_q;
`endif
    end

endmodule

// File: tb/tb_priority_encoder83.sv
// tb/tb_priority_encoder83.sv - randomized and directed bench for priority_encoder83
module tb_priority_encoder83;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic       ack;
    logic [2:0] code;
    logic       valid;
    logic       gs;
    logic [7:0] pending;
`ifdef PENC_OVERRUN_EN
    logic       overrun;
`endif

    priority_encoder83 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .req     (req),
        .ack     (ack),
        .code    (code),
        .valid   (valid),
        .gs      (gs),
        .pending (pending)
`ifdef PENC_OVERRUN_EN
        ,
        .overrun (overrun)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: the set of outstanding requests and the current grant.
    int m_pend;
    bit m_valid;
    int m_code;
    bit m_ovr;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    function automatic int highest(input int set);
        for (int i = 7; i >= 0; i--) begin
            if (set[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_edge(input bit r, input bit e, input int rq, input bit a);
        int clr;
        if (!r) begin
            m_pend = 0; m_valid = 0; m_code = 0; m_ovr = 0;
            return;
        end
        clr = (m_valid && a) ? (1 << m_code) : 0;
        if ((rq & m_pend & ~clr) != 0) m_ovr = 1;
        if (m_valid) begin
            if (a) m_valid = 0;
        end else if (e && m_pend != 0) begin
            m_code  = highest(m_pend);
            m_valid = 1;
        end
        m_pend = ((m_pend & ~clr) | rq) & 8'hFF;
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare.
    task automatic step(input bit r, input bit e, input logic [7:0] rq, input bit a);
        rst_n = r; en = e; req = rq; ack = a;
        @(posedge clk);
        model_edge(r, e, int'(rq), a);
        #1;
        check("pending", int'(pending), m_pend);
        check("valid", int'(valid), int'(m_valid));
        check("gs", int'(gs), int'(m_pend != 0));
        if (m_valid) check("code", int'(code), m_code);
        else if (!r) check("code_reset", int'(code), 0);
`ifdef PENC_OVERRUN_EN
        check("overrun", int'(overrun), int'(m_ovr));
`endif
    endtask

    int         grants[$];
    logic [6:0] vseq;

    initial begin
        rst_n = 1'b0; en = 1'b0; req = 8'h00; ack = 1'b0;
        m_pend = 0; m_valid = 0; m_code = 0; m_ovr = 0;

        step(0, 0, 8'h00, 0);
        step(0, 0, 8'h00, 0);
        check("lit_reset_pending", int'(pending), 0);
        check("lit_reset_valid", int'(valid), 0);
        check("lit_reset_code", int'(code), 0);
        check("lit_reset_gs", int'(gs), 0);

        // Priority ordering with ack tied high.
        vseq = '0;
        step(1, 1, 8'b0010_0110, 1);
        vseq = {vseq[5:0], valid};
        for (int k = 0; k < 6; k++) begin
            step(1, 1, 8'h00, 1);
            vseq = {vseq[5:0], valid};
            if (valid) grants.push_back(int'(code));
        end
        check("lit_prio_count", grants.size(), 3);
        if (grants.size() == 3) begin
            check("lit_prio_g0", grants[0], 5);
            check("lit_prio_g1", grants[1], 2);
            check("lit_prio_g2", grants[2], 1);
        end
        check("lit_prio_valid_pattern", int'(vseq), int'(7'b0101010));
        check("lit_prio_end_pending", int'(pending), 0);
        check("lit_prio_end_gs", int'(gs), 0);

        // Hold under pressure.
        step(1, 1, 8'h08, 0);
        step(1, 1, 8'h00, 0);
        for (int k = 0; k < 4; k++) begin
            step(1, 0, 8'h80, 0);
            check("lit_hold_code", int'(code), 3);
            check("lit_hold_valid", int'(valid), 1);
        end
        step(1, 0, 8'h00, 1);
        check("lit_hold_acked", int'(valid), 0);
        step(1, 0, 8'h00, 0);
        step(1, 0, 8'h00, 0);
        check("lit_hold_gated", int'(valid), 0);
        step(1, 1, 8'h00, 0);
        check("lit_hold_next_valid", int'(valid), 1);
        check("lit_hold_next_code", int'(code), 7);
        step(1, 1, 8'h00, 1);

        // Set wins over clear on the same bit.
        step(1, 1, 8'h10, 0);
        step(1, 1, 8'h00, 0);
        check("lit_col_code", int'(code), 4);
        step(1, 1, 8'h10, 1);
        check("lit_col_pending4", int'(pending[4]), 1);
        step(1, 1, 8'h00, 0);
        check("lit_col_regrant_valid", int'(valid), 1);
        check("lit_col_regrant_code", int'(code), 4);
        step(1, 1, 8'h00, 1);

        // Enable gating.
        step(1, 0, 8'h01, 0);
        step(1, 0, 8'h00, 0);
        step(1, 0, 8'h00, 0);
        check("lit_en_valid", int'(valid), 0);
        check("lit_en_gs", int'(gs), 1);
        check("lit_en_pending", int'(pending), 1);
        step(1, 1, 8'h00, 0);
        check("lit_en_grant_valid", int'(valid), 1);
        check("lit_en_grant_code", int'(code), 0);
        step(1, 1, 8'h00, 1);

        // Reset in the middle of a handshake.
        step(1, 1, 8'hA0, 0);
        step(1, 1, 8'h00, 0);
        check("lit_rst_pre_code", int'(code), 7);
        step(0, 1, 8'h00, 1);
        check("lit_rst_pending", int'(pending), 0);
        check("lit_rst_valid", int'(valid), 0);
        check("lit_rst_code", int'(code), 0);
        check("lit_rst_gs", int'(gs), 0);

`ifdef PENC_OVERRUN_EN
        step(1, 0, 8'h40, 0);
        step(1, 0, 8'h40, 0);
        check("lit_overrun_set", int'(overrun), 1);
        for (int k = 0; k < 5; k++) begin
            step(1, 1, 8'h00, 1);
            check("lit_overrun_sticky", int'(overrun), 1);
        end
        step(0, 0, 8'h00, 0);
        check("lit_overrun_reset", int'(overrun), 0);
`endif

        // Random traffic with sparse requests.
        for (int k = 0; k < 600; k++) begin
            logic [7:0] rq;
            for (int b = 0; b < 8; b++) rq[b] = ($urandom_range(0, 7) == 0);
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0),
                 rq, ($urandom_range(0, 2) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
